// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the FIR sample serial transmitter.
//   tx_state_t      : transmit FSM state encoding (TX_PARITY exists only
//                     when FIR_TX_PARITY_EN is defined)
//   FIR_N_DEFAULT   : default sample width in bits
//   frame_cycles()  : clk cycles occupied by one serial frame
package fir_pkg;

    localparam int unsigned FIR_N_DEFAULT = 32'd32;

`ifdef FIR_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_LOAD   = 3'd1,
        TX_SHIFT  = 3'd2,
        TX_PARITY = 3'd3,
        TX_GAP    = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_LOAD  = 2'd1,
        TX_SHIFT = 2'd2,
        TX_GAP   = 2'd3
    } tx_state_t;
`endif

    // One frame = N data bit periods + gap (+ parity bit period), each 2*bit_div clks
    function automatic int unsigned frame_cycles(input int unsigned n,
                                                 input int unsigned bit_div);
`ifdef FIR_TX_PARITY_EN
        return (n + 32'd2) * 32'd2 * bit_div;
`else
        return (n + 32'd1) * 32'd2 * bit_div;
`endif
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo -- first-word-fall-through sample buffer.
//   clk, rst  : clock, asynchronous active-low reset
//   push, din : write request and data; dropped when full unless popped same cycle
//   pop, dout : read request and current head word (valid while !empty)
//   full      : FIFO_DEPTH words held
//   empty     : no words held
module fir_sample_fifo #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign rd_en_s = pop && !empty_r;
    assign wr_en_s = push && (!full_r || rd_en_s);

    // Occupancy after this cycle's accepted write/read
    always_comb begin
        count_nxt_s = count_r;
        if (wr_en_s && !rd_en_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (rd_en_s && !wr_en_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(FIFO_DEPTH));
            empty_r <= (count_nxt_s == CW'(0));
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/fir_sample_tx.sv
// fir_sample_tx -- serialises FIR output samples, MSB first, on sclk/sdata/ws.
// Optional build macro: FIR_TX_PARITY_EN adds one even-parity bit period after the LSB.
//   clk        : system clock            rst      : async active-low reset
//   clk_d      : divided sample clock; each rising edge pushes sample_in
//   ena        : push enable (an in-flight frame and queued samples always drain)
//   sample_in  : N-bit sample           sclk     : serial bit clock, low when idle
//   sdata      : serial data            ws       : high during the N data bit periods
//   busy       : FSM active or FIFO non-empty
//   overflow   : sticky, set when a push meets a full FIFO
module fir_sample_tx
    import fir_pkg::*;
#(
    parameter int N          = FIR_N_DEFAULT,
    parameter int BIT_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_d,
    input  logic         ena,
    input  logic [N-1:0] sample_in,
    output logic         sclk,
    output logic         sdata,
    output logic         ws,
    output logic         busy,
    output logic         overflow
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BIT_W = $clog2(N);

    tx_state_t        state_r;
    logic [N-1:0]     shreg_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             clk_d_q_r;
    logic             sclk_r;
    logic             sdata_r;
    logic             ws_r;
    logic             ovf_r;
    logic             push_s;
    logic             pop_s;
    logic             div_wrap_s;
    logic             sclk_fall_s;
    logic [N-1:0]     fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
`ifdef FIR_TX_PARITY_EN
    logic             par_r;

    function automatic logic even_parity(input logic [N-1:0] word);
        return ^word;
    endfunction
`endif

    assign push_s      = clk_d && !clk_d_q_r && ena;
    assign div_wrap_s  = (div_cnt_r == DIV_W'(BIT_DIV - 1));
    assign sclk_fall_s = div_wrap_s && sclk_r;
    // Head is taken when idle, or at the close of a gap so frames stay back-to-back
    assign pop_s       = !fifo_empty_s &&
                         ((state_r == TX_IDLE) || ((state_r == TX_GAP) && sclk_fall_s));

    fir_sample_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (sample_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Edge detector, sticky overflow, bit-clock divider and transmit FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Held high so a clk_d already high at release is not taken as a push
            clk_d_q_r <= 1'b1;
            state_r   <= TX_IDLE;
            shreg_r   <= '0;
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            sclk_r    <= 1'b0;
            sdata_r   <= 1'b0;
            ws_r      <= 1'b0;
            ovf_r     <= 1'b0;
`ifdef FIR_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            clk_d_q_r <= clk_d;
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end

            if (state_r == TX_IDLE) begin
                div_cnt_r <= '0;
                sclk_r    <= 1'b0;
            end else if (div_wrap_s) begin
                div_cnt_r <= '0;
                sclk_r    <= ~sclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end

            case (state_r)
                TX_IDLE: state_r <= TX_IDLE;
                TX_LOAD: state_r <= TX_SHIFT;
                TX_SHIFT: begin
                    if (sclk_fall_s) begin
                        if (bit_cnt_r == BIT_W'(N - 1)) begin
                            ws_r <= 1'b0;
`ifdef FIR_TX_PARITY_EN
                            state_r <= TX_PARITY;
                            sdata_r <= par_r;
`else
                            state_r <= TX_GAP;
                            sdata_r <= 1'b0;
`endif
                        end else begin
                            shreg_r   <= {shreg_r[N-2:0], 1'b0};
                            sdata_r   <= shreg_r[N-2];
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end
                end
`ifdef FIR_TX_PARITY_EN
                TX_PARITY: begin
                    if (sclk_fall_s) begin
                        state_r <= TX_GAP;
                        sdata_r <= 1'b0;
                    end
                end
`endif
                TX_GAP: begin
                    // Divider already brings sclk low on this edge
                    if (sclk_fall_s) begin
                        state_r <= TX_IDLE;
                    end
                end
                default: state_r <= TX_IDLE;
            endcase

            // Load overrides the per-state updates above
            if (pop_s) begin
                state_r   <= TX_LOAD;
                shreg_r   <= fifo_dout_s;
                sdata_r   <= fifo_dout_s[N-1];
                ws_r      <= 1'b1;
                bit_cnt_r <= '0;
                div_cnt_r <= '0;
                sclk_r    <= 1'b0;
`ifdef FIR_TX_PARITY_EN
                par_r     <= even_parity(fifo_dout_s);
`endif
            end
        end
    end

    assign sclk     = sclk_r;
    assign sdata    = sdata_r;
    assign ws       = ws_r;
    assign overflow = ovf_r;
    assign busy     = (state_r != TX_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_fir_sample_tx.sv
// tb_fir_sample_tx -- scoreboard bench for fir_sample_tx (N=32, BIT_DIV=2, FIFO_DEPTH=4).
// Stimulus pushes samples in bursts starting from idle and queues the expected
// words; a monitor decodes the serial stream and compares each frame.
`timescale 1ns/1ps
module tb_fir_sample_tx;
    import fir_pkg::*;

    localparam int N          = 32;
    localparam int BIT_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = int'(frame_cycles(N, BIT_DIV));
    localparam int WS_LEN     = N * 2 * BIT_DIV;
`ifdef FIR_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clk_d = 1'b0;
    logic         ena = 1'b0;
    logic [N-1:0] sample_in = '0;
    logic         sclk, sdata, ws, busy, overflow;

    fir_sample_tx #(.N(N), .BIT_DIV(BIT_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .clk_d(clk_d), .ena(ena), .sample_in(sample_in),
        .sclk(sclk), .sdata(sdata), .ws(ws), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] exp_q[$];
    int           start_q[$];
    int           frames_started = 0;
    int           burst_acc = 0;
    logic         exp_ovf = 1'b0;
    int           cyc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- monitor: decode serial frames ----------------
    logic         prev_ws = 1'b0;
    logic         prev_sclk = 1'b0;
    logic [N-1:0] cap = '0;
    logic         par_cap = 1'b0;
    int           nb = 0;
    int           ws_cnt = 0;
    int           phase = 0;   // 0 none, 1 data, 2 parity, 3 gap

    function automatic void finish_frame();
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", cap);
        end else begin
            e = exp_q.pop_front();
            check("frame_word", cap, e);
            if (PAR_EN) check("parity_bit", par_cap, ^e);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            phase     = 0;
            prev_ws   = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            if (ws && !prev_ws) begin
                check("ws_rise_in_frame", phase, 0);
                phase = 1; nb = 0; cap = '0; ws_cnt = 0;
                start_q.push_back(cyc);
                frames_started++;
            end
            if (ws) ws_cnt++;
            if (sclk && !prev_sclk) begin
                case (phase)
                    1: begin cap = {cap[N-2:0], sdata}; nb++; end
                    2: begin par_cap = sdata; phase = 3; end
                    3: begin check("gap_sdata", sdata, 0); finish_frame(); phase = 0; end
                    default: check("sclk_outside_frame", sclk, 0);
                endcase
            end
            if (!ws && prev_ws) begin
                check("ws_len", ws_cnt, WS_LEN);
                check("bit_count", nb, N);
                phase = PAR_EN ? 2 : 3;
            end
            prev_ws   = ws;
            prev_sclk = sclk;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic begin_burst();
        start_q.delete();
        burst_acc = 0;
    endtask

    // One clk_d period of 4 clk; model: from idle, the first FIFO_DEPTH+1
    // enabled pushes are sent (one in the shifter, FIFO_DEPTH queued), later ones overflow
    task automatic do_push(input logic [N-1:0] v, input logic en);
        @(negedge clk);
        sample_in = v; ena = en; clk_d = 1'b1;
        if (en) begin
            if (burst_acc < FIFO_DEPTH + 1) begin
                exp_q.push_back(v);
                burst_acc++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        repeat (2) @(negedge clk);
        clk_d = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy && t < 3000) begin @(negedge clk); t++; end
        check({name, "_timeout"}, (t < 3000), 1'b1);
        repeat (2) @(negedge clk);
        check({name, "_busy"}, busy, 0);
        check({name, "_sclk_idle"}, sclk, 0);
        check({name, "_ws_idle"}, ws, 0);
        check({name, "_sdata_idle"}, sdata, 0);
        check({name, "_overflow"}, overflow, exp_ovf);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_frames"}, start_q.size(), burst_acc);
        for (int i = 1; i < start_q.size(); i++)
            check({name, "_b2b"}, start_q[i] - start_q[i-1], FRAME);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fs;
        int rises;
        int t;
        logic ps;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_ws", ws, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single frame 1000
        begin_burst(); do_push(32'd1000, 1'b1); wait_idle("single_1000");
        // back-to-back -1 then 193
        begin_burst(); do_push(32'hFFFF_FFFF, 1'b1); do_push(32'd193, 1'b1); wait_idle("b2b");
        // parity patterns
        begin_burst(); do_push(32'h0000_0007, 1'b1); do_push(32'h0000_0003, 1'b1); wait_idle("par_words");

        // push with ena low: nothing happens
        fs = frames_started;
        begin_burst(); do_push(32'd376, 1'b0);
        check("ena0_busy", busy, 0);
        repeat (200) @(negedge clk);
        check("ena0_busy_late", busy, 0);
        check("ena0_no_frame", frames_started, fs);

        // ena dropped mid-frame: frame completes, new push blocked
        begin_burst(); do_push(32'h1234_5678, 1'b1);
        repeat (40) @(negedge clk);
        ena = 1'b0;
        do_push(32'd55, 1'b0);
        wait_idle("ena_mid");

        // overflow: six pushes, five frames
        begin_burst();
        for (int i = 0; i < 6; i++) do_push($urandom(), 1'b1);
        wait_idle("overflow6");

        // random bursts
        for (int b = 0; b < 10; b++) begin
            int k;
            k = int'($urandom_range(6, 1));
            begin_burst();
            for (int i = 0; i < k; i++) do_push($urandom(), ($urandom_range(3, 0) != 0));
            wait_idle("rand");
        end

        // reset at bit 10 of a frame
        begin_burst(); do_push($urandom(), 1'b1);
        rises = 0; t = 0; ps = sclk;
        while (rises < 10 && t < 2000) begin
            @(negedge clk);
            if (sclk && !ps) rises++;
            ps = sclk; t++;
        end
        check("bit10_reached", rises, 10);
        #2 rst = 1'b0;
        #1;
        check("async_rst_sclk", sclk, 0);
        check("async_rst_sdata", sdata, 0);
        check("async_rst_ws", ws, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overflow", overflow, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        fs = frames_started;
        repeat (300) @(negedge clk);
        check("post_rst_no_frame", frames_started, fs);
        check("post_rst_busy", busy, 0);
        begin_burst(); do_push($urandom(), 1'b1); wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
